flags_counter_register_file: RTL and testbench

- Parametrised successor to the single-bit RX/RTR flags register file in the photonic-interconnect microprocessor.
- Each channel holds a saturating message counter instead of a 1-bit flag. The network receive side increments it (rx) and the core's ready-to-receive consume decrements it (rtr).
- A blocking-receive port stalls the core until the addressed channel has a pending message, then consumes that message automatically.
- Sits between the photonic NIC receive logic and the core's register-read/stall logic.

---
 rtl/flags_pkg.sv | 45 ++++
 rtl/flags_wait_fsm.sv | 60 ++++++
 rtl/flags_counter_register_file.sv | 97 +++++++++
 tb/tb_flags_counter_register_file.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/flags_pkg.sv
// Shared types for the flags counter register file: wait FSM states and the
// saturating per-channel counter update.
package flags_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } wait_state_t;

  typedef struct packed {
    logic [31:0] count;
    logic        overflow;
    logic        underflow;
  } count_result_t;

  // The wait consume is applied together with rtr, so a count of 1 hit by both
  // lands at -1: it clamps to 0 and reports underflow.
  function automatic count_result_t next_count(
    input logic [31:0] count,
    input logic        inc,
    input logic        dec_rtr,
    input logic        dec_wait,
    input logic [31:0] max_count
  );
    count_result_t res;
    int            sum;
    res = '0;
    sum = int'(count);
    if (inc)      sum = sum + 1;
    if (dec_rtr)  sum = sum - 1;
    if (dec_wait) sum = sum - 1;
    if (sum > int'(max_count)) begin
      res.count    = max_count;
      res.overflow = 1'b1;
    end else if (sum < 0) begin
      res.count     = '0;
      res.underflow = 1'b1;
    end else begin
      res.count = 32'(sum);
    end
    return res;
  endfunction

endpackage

// File: rtl/flags_wait_fsm.sv
// Blocking-receive controller: latches the channel, stalls until it has a
// pending message, consumes it and pulses wait_done for one cycle.
module flags_wait_fsm
  import flags_pkg::*;
#(
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wait_request,
  input  logic [ADDR_WIDTH-1:0] wait_address,
  input  logic                  pending,
  output logic                  consume_enable,
  output logic [ADDR_WIDTH-1:0] consume_address,
  output logic                  wait_stall,
  output logic                  wait_done
);

  wait_state_t           state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    consume_enable = 1'b0;
    case (state_reg)
      IDLE: begin
        if (wait_request) begin
          addr_next  = wait_address;
          state_next = WAIT;
        end
      end
      WAIT: begin
        // pending comes from registered counters, so an rx landing this
        // same edge is only seen next cycle
        if (pending) begin
          consume_enable = 1'b1;
          state_next     = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign consume_address = addr_reg;
  assign wait_stall      = (state_reg == WAIT);
  assign wait_done       = (state_reg == DONE);

endmodule

// File: rtl/flags_counter_register_file.sv
// Per-channel saturating message counters with rx increment, rtr decrement,
// a blocking-receive consumer and sticky overflow/underflow flags.
module flags_counter_register_file
  import flags_pkg::*;
#(
  parameter  int NUM_FLAGS   = 4,
  parameter  int COUNT_WIDTH = 2,
  localparam int ADDR_WIDTH  = $clog2(NUM_FLAGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_write_enable,
  input  logic [ADDR_WIDTH-1:0]  rx_address,
  input  logic                   rtr_write_enable,
  input  logic [ADDR_WIDTH-1:0]  rtr_address,
  input  logic [ADDR_WIDTH-1:0]  address_1,
  output logic                   read_data,
  input  logic [ADDR_WIDTH-1:0]  address_2,
  output logic [COUNT_WIDTH-1:0] read_count,
  output logic [NUM_FLAGS-1:0]   flags_vector,
  input  logic                   wait_request,
  input  logic [ADDR_WIDTH-1:0]  wait_address,
  output logic                   wait_stall,
  output logic                   wait_done,
  output logic                   overflow,
  output logic                   underflow
);

  localparam logic [31:0] MAX_COUNT = 32'((1 << COUNT_WIDTH) - 1);

  logic [NUM_FLAGS-1:0][COUNT_WIDTH-1:0] count_reg, count_next;
  count_result_t [NUM_FLAGS-1:0]         result;
  logic [NUM_FLAGS-1:0]                  ovf_bits, unf_bits;
  logic                                  overflow_reg, underflow_reg;
  logic                                  consume_enable, pending;
  logic [ADDR_WIDTH-1:0]                 consume_address;

  // Out-of-range addresses match no channel, so their writes drop silently
  // and a wait on them never sees a pending message.
  generate
    for (genvar gi = 0; gi < NUM_FLAGS; gi++) begin : g_chan
      logic rx_hit, rtr_hit, wait_hit;
      logic [31-COUNT_WIDTH:0] count_hi_unused;
      assign rx_hit   = rx_write_enable  && (rx_address == ADDR_WIDTH'(gi));
      assign rtr_hit  = rtr_write_enable && (rtr_address == ADDR_WIDTH'(gi));
      assign wait_hit = consume_enable   && (consume_address == ADDR_WIDTH'(gi));
      assign result[gi] = next_count(32'(count_reg[gi]), rx_hit, rtr_hit,
                                     wait_hit, MAX_COUNT);
      assign count_next[gi]   = result[gi].count[COUNT_WIDTH-1:0];
      assign count_hi_unused  = result[gi].count[31:COUNT_WIDTH];
      assign ovf_bits[gi]     = result[gi].overflow;
      assign unf_bits[gi]     = result[gi].underflow;
      assign flags_vector[gi] = (count_reg[gi] != '0);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      count_reg     <= count_next;
      overflow_reg  <= overflow_reg | (|ovf_bits);
      underflow_reg <= underflow_reg | (|unf_bits);
    end
  end

  always_comb begin
    read_data  = 1'b0;
    read_count = '0;
    pending    = 1'b0;
    for (int i = 0; i < NUM_FLAGS; i++) begin
      if (address_1 == ADDR_WIDTH'(i))       read_data  = flags_vector[i];
      if (address_2 == ADDR_WIDTH'(i))       read_count = count_reg[i];
      if (consume_address == ADDR_WIDTH'(i)) pending    = flags_vector[i];
    end
  end

  flags_wait_fsm #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_wait_fsm (
    .clk            (clk),
    .reset          (reset),
    .wait_request   (wait_request),
    .wait_address   (wait_address),
    .pending        (pending),
    .consume_enable (consume_enable),
    .consume_address(consume_address),
    .wait_stall     (wait_stall),
    .wait_done      (wait_done)
  );

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: tb/tb_flags_counter_register_file.sv
// Directed bench: a 4-channel instance for counting/wait behaviour and a
// 5-channel instance for out-of-range addressing and reset mid-wait.
module tb_flags_counter_register_file;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 4-channel instance
  logic       rx_we, rtr_we, wreq, rd_data, stall, done, ovf, unf;
  logic [1:0] rx_addr, rtr_addr, a1, a2, waddr, rd_count;
  logic [3:0] flags;

  flags_counter_register_file #(.NUM_FLAGS(4), .COUNT_WIDTH(2)) dut (
    .clk(clk), .reset(reset),
    .rx_write_enable(rx_we), .rx_address(rx_addr),
    .rtr_write_enable(rtr_we), .rtr_address(rtr_addr),
    .address_1(a1), .read_data(rd_data),
    .address_2(a2), .read_count(rd_count),
    .flags_vector(flags),
    .wait_request(wreq), .wait_address(waddr),
    .wait_stall(stall), .wait_done(done),
    .overflow(ovf), .underflow(unf)
  );

  // 5-channel instance
  logic       f5_rx_we, f5_rtr_we, f5_wreq, f5_rd_data, f5_stall, f5_done, f5_ovf, f5_unf;
  logic [2:0] f5_rx_addr, f5_rtr_addr, f5_a1, f5_a2, f5_waddr;
  logic [1:0] f5_rd_count;
  logic [4:0] f5_flags;

  flags_counter_register_file #(.NUM_FLAGS(5), .COUNT_WIDTH(2)) dut5 (
    .clk(clk), .reset(reset),
    .rx_write_enable(f5_rx_we), .rx_address(f5_rx_addr),
    .rtr_write_enable(f5_rtr_we), .rtr_address(f5_rtr_addr),
    .address_1(f5_a1), .read_data(f5_rd_data),
    .address_2(f5_a2), .read_count(f5_rd_count),
    .flags_vector(f5_flags),
    .wait_request(f5_wreq), .wait_address(f5_waddr),
    .wait_stall(f5_stall), .wait_done(f5_done),
    .overflow(f5_ovf), .underflow(f5_unf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    rx_we = 0; rtr_we = 0; wreq = 0; rx_addr = 0; rtr_addr = 0; a1 = 0; a2 = 0; waddr = 0;
    f5_rx_we = 0; f5_rtr_we = 0; f5_wreq = 0; f5_rx_addr = 0; f5_rtr_addr = 0;
    f5_a1 = 0; f5_a2 = 0; f5_waddr = 0;
    tick(); tick();
    reset = 1'b0;

    $display("step: reset state");
    check("rst_count", 32'(rd_count), 0);
    check("rst_data", 32'(rd_data), 0);
    check("rst_flags", 32'(flags), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_unf", 32'(unf), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_done", 32'(done), 0);

    $display("step: rx x3 on ch2");
    rx_we = 1; rx_addr = 2; a1 = 2; a2 = 2;
    tick(); tick(); tick();
    rx_we = 0;
    check("ch2_count3", 32'(rd_count), 3);
    check("ch2_flags", 32'(flags), 32'b0100);
    check("ch2_data", 32'(rd_data), 1);
    check("ch2_no_ovf", 32'(ovf), 0);

    $display("step: 4th rx on ch2 saturates");
    rx_we = 1;
    tick();
    rx_we = 0;
    check("sat_count", 32'(rd_count), 3);
    check("sat_ovf", 32'(ovf), 1);

    $display("step: rtr on ch1 at zero");
    rtr_we = 1; rtr_addr = 1; a2 = 1; a1 = 1;
    tick();
    rtr_we = 0;
    check("unf_count", 32'(rd_count), 0);
    check("unf_data", 32'(rd_data), 0);
    check("unf_flag", 32'(unf), 1);
    check("ovf_sticky", 32'(ovf), 1);

    $display("step: reset clears sticky flags");
    reset = 1;
    tick();
    reset = 0;
    check("rst2_unf", 32'(unf), 0);
    check("rst2_ovf", 32'(ovf), 0);
    check("rst2_flags", 32'(flags), 0);

    $display("step: rx+rtr same cycle on ch0 at count 1");
    rx_we = 1; rx_addr = 0; a2 = 0;
    tick();
    check("ch0_count1", 32'(rd_count), 1);
    rtr_we = 1; rtr_addr = 0;
    tick();
    rx_we = 0; rtr_we = 0;
    check("net0_count", 32'(rd_count), 1);
    check("net0_ovf", 32'(ovf), 0);
    check("net0_unf", 32'(unf), 0);

    $display("step: blocking wait on ch3");
    wreq = 1; waddr = 3; a2 = 3;
    tick();
    wreq = 0;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("w3_stall_c%0d", c), 32'(stall), 1);
      check($sformatf("w3_done_c%0d", c), 32'(done), 0);
      tick();
    end
    check("w3_stall_c4", 32'(stall), 1);
    rx_we = 1; rx_addr = 3;
    tick();
    rx_we = 0;
    check("w3_stall_c5", 32'(stall), 1);
    check("w3_done_c5", 32'(done), 0);
    check("w3_count_c5", 32'(rd_count), 1);
    tick();
    check("w3_done_c6", 32'(done), 1);
    check("w3_stall_c6", 32'(stall), 0);
    check("w3_count_c6", 32'(rd_count), 0);
    tick();
    check("w3_done_c7", 32'(done), 0);
    check("w3_stall_c7", 32'(stall), 0);

    $display("step: wait on ch1 with rtr in consume cycle");
    rx_we = 1; rx_addr = 1; a2 = 1;
    tick();
    rx_we = 0;
    check("w1_count1", 32'(rd_count), 1);
    wreq = 1; waddr = 1;
    tick();
    wreq = 0;
    check("w1_stall", 32'(stall), 1);
    rtr_we = 1; rtr_addr = 1;
    tick();
    rtr_we = 0;
    check("w1_done", 32'(done), 1);
    check("w1_count0", 32'(rd_count), 0);
    check("w1_unf", 32'(unf), 1);
    // request during DONE is ignored
    wreq = 1; waddr = 0;
    tick();
    wreq = 0;
    check("done_req_stall", 32'(stall), 0);
    check("done_req_done", 32'(done), 0);
    tick();
    check("done_req_idle", 32'(stall), 0);

    $display("step: 5-channel out-of-range address 6");
    f5_rx_we = 1; f5_rx_addr = 4;
    tick();
    f5_rx_addr = 6; f5_a1 = 6; f5_a2 = 6;
    tick();
    f5_rx_we = 0;
    f5_rtr_we = 1; f5_rtr_addr = 6;
    tick();
    f5_rtr_we = 0;
    check("oor_flags", 32'(f5_flags), 32'b10000);
    check("oor_count", 32'(f5_rd_count), 0);
    check("oor_data", 32'(f5_rd_data), 0);
    check("oor_ovf", 32'(f5_ovf), 0);
    check("oor_unf", 32'(f5_unf), 0);
    f5_a2 = 4; f5_a1 = 4;
    #1;
    check("ch4_count", 32'(f5_rd_count), 1);
    check("ch4_data", 32'(f5_rd_data), 1);

    $display("step: wait on address 6 then reset mid-wait");
    f5_wreq = 1; f5_waddr = 6;
    tick();
    f5_wreq = 0;
    f5_rx_we = 1; f5_rx_addr = 6;
    tick(); tick(); tick();
    f5_rx_we = 0;
    check("oor_wait_stall", 32'(f5_stall), 1);
    check("oor_wait_done", 32'(f5_done), 0);
    reset = 1;
    tick();
    reset = 0;
    check("abort_stall", 32'(f5_stall), 0);
    check("abort_done", 32'(f5_done), 0);
    tick();
    check("abort_done2", 32'(f5_done), 0);
    check("abort_stall2", 32'(f5_stall), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
